// File: rtl/trng_pkg.sv
// trng_pkg: shared types for the TRNG word server.
//   trng_op_e    - Op_Type codes driven alongside TRNG_Go
//   trng_state_e - request/unpack FSM states
package trng_pkg;

    typedef enum logic [1:0] {
        OpInit  = 2'h0,
        OpCond1 = 2'h1,
        OpCond2 = 2'h2,
        OpCond3 = 2'h3
    } trng_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StUnpack
    } trng_state_e;

    // One 128-bit TRNG result yields this many 32-bit FIFO words.
    localparam int unsigned WORDS_PER_BLOCK = 4;

endpackage

// File: rtl/trng_word_fifo.sv
// trng_word_fifo: 32-bit wide, Depth-deep FIFO with occupancy count and a
// registered head word.
// Ports:
//   clk, Resetn       clock, asynchronous active-low reset
//   push, push_data   write one word (ignored when full)
//   pop               remove the head word (ignored when empty)
//   count             number of words held
//   head              registered head word; 0 when empty
module trng_word_fifo #(
    parameter int unsigned Depth = 16
) (
    input  logic                       clk,
    input  logic                       Resetn,
    input  logic                       push,
    input  logic [31:0]                push_data,
    input  logic                       pop,
    output logic [$clog2(Depth):0]     count,
    output logic [31:0]                head
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_q, head_d;
    logic          do_push, do_pop;

    assign do_push = push && (count_q != CW'(Depth));
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        // Depth is a power of two, so the pointers wrap naturally.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Next head: the pushed word if it lands in an empty (or emptying) FIFO,
        // otherwise an entry already stored.
        if (count_d == '0) begin
            head_d = '0;
        end else if ((count_q == '0) || ((count_q == CW'(1)) && do_pop)) begin
            head_d = push_data;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/trng_word_server.sv
// trng_word_server: keeps a word FIFO topped up from the TRNG Go/Done interface
// and serves 32-bit words over a valid/ready port.
// Ports:
//   clk, Resetn              clock, asynchronous active-low reset
//   enable                   allow automatic refill requests
//   TRNG_Go, Op_Type         request pulse and its operation type
//   TRNG_Done, trng_data     completion pulse and 128-bit result
//   rnd_valid/ready/data     word output port (data is 0 when empty)
//   fill_level               words currently buffered
//   timeout_err              sticky: a request got no Done in time
//   rep_err                  sticky: a block repeated the previous one
//                            (only when TRNG_REPCHECK_EN is defined)
// Build option: TRNG_REPCHECK_EN enables the repeated-block check.
module trng_word_server
    import trng_pkg::*;
#(
    parameter int unsigned P_DEPTH    = 16,
    parameter int unsigned P_TIMEOUT  = 4096,
    parameter logic [1:0]  P_OP_REFIL = 2'h1
) (
    input  logic                        clk,
    input  logic                        Resetn,
    input  logic                        enable,
    output logic                        TRNG_Go,
    output logic [1:0]                  Op_Type,
    input  logic                        TRNG_Done,
    input  logic [127:0]                trng_data,
    output logic                        rnd_valid,
    input  logic                        rnd_ready,
    output logic [31:0]                 rnd_data,
    output logic [$clog2(P_DEPTH):0]    fill_level,
    output logic                        timeout_err
`ifdef TRNG_REPCHECK_EN
    ,
    output logic                        rep_err
`endif
);

    localparam int unsigned CW = $clog2(P_DEPTH) + 1;
    localparam int unsigned TW = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;

    trng_state_e   state_q;
    logic          init_done_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [127:0]  hold_q;
    logic [1:0]    word_idx_q;
    logic          go_q;
    logic [1:0]    op_q;
    logic          timeout_err_q;
`ifdef TRNG_REPCHECK_EN
    logic [127:0]  prev_q;
    logic          prev_vld_q;
    logic          rep_err_q;
`endif

    logic          space_ok;
    logic          push;
    logic [31:0]   push_data;
    logic          pop;

    // Room for a whole block is checked before issuing, so UNPACK never overflows.
    assign space_ok = fill_level <= CW'(P_DEPTH - WORDS_PER_BLOCK);
    assign push     = (state_q == StUnpack);
    assign pop      = rnd_valid && rnd_ready;

    always_comb begin
        push_data = hold_q[31:0];
        unique case (word_idx_q)
            2'd0: push_data = hold_q[31:0];
            2'd1: push_data = hold_q[63:32];
            2'd2: push_data = hold_q[95:64];
            2'd3: push_data = hold_q[127:96];
            default: push_data = hold_q[31:0];
        endcase
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= StIdle;
            init_done_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            hold_q        <= '0;
            word_idx_q    <= '0;
            go_q          <= 1'b0;
            op_q          <= '0;
            timeout_err_q <= 1'b0;
`ifdef TRNG_REPCHECK_EN
            prev_q        <= '0;
            prev_vld_q    <= 1'b0;
            rep_err_q     <= 1'b0;
`endif
        end else begin
            go_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable && space_ok) begin
                        // Go and Op_Type are registered, so they are set on entry to ISSUE.
                        go_q    <= 1'b1;
                        op_q    <= init_done_q ? P_OP_REFIL : 2'(OpInit);
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    init_done_q <= 1'b1;
                    tmo_cnt_q   <= '0;
                    state_q     <= StWait;
                end
                StWait: begin
                    if (TRNG_Done) begin
`ifdef TRNG_REPCHECK_EN
                        if (prev_vld_q && (trng_data == prev_q)) begin
                            rep_err_q <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            prev_q     <= trng_data;
                            prev_vld_q <= 1'b1;
                            hold_q     <= trng_data;
                            word_idx_q <= '0;
                            state_q    <= StUnpack;
                        end
`else
                        hold_q     <= trng_data;
                        word_idx_q <= '0;
                        state_q    <= StUnpack;
`endif
                    end else if (tmo_cnt_q == TW'(P_TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= StIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                StUnpack: begin
                    word_idx_q <= word_idx_q + 2'd1;
                    if (word_idx_q == 2'd3) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    trng_word_fifo #(
        .Depth (P_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .Resetn    (Resetn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (fill_level),
        .head      (rnd_data)
    );

    assign rnd_valid   = (fill_level != '0);
    assign TRNG_Go     = go_q;
    assign Op_Type     = op_q;
    assign timeout_err = timeout_err_q;
`ifdef TRNG_REPCHECK_EN
    assign rep_err     = rep_err_q;
`endif

endmodule

// File: tb/tb_trng_word_server.sv
// Directed bench for trng_word_server (P_DEPTH=16, P_TIMEOUT=16) with a
// behavioural TRNG responder and a word consumer. The repeated-block test
// runs only when TRNG_REPCHECK_EN is defined.
module tb_trng_word_server;

    logic         clk = 1'b0;
    logic         Resetn;
    logic         enable;
    logic         TRNG_Go;
    logic [1:0]   Op_Type;
    logic         TRNG_Done;
    logic [127:0] trng_data;
    logic         rnd_valid;
    logic         rnd_ready;
    logic [31:0]  rnd_data;
    logic [4:0]   fill_level;
    logic         timeout_err;
`ifdef TRNG_REPCHECK_EN
    logic         rep_err;
`endif

    always #5 clk = ~clk;

    trng_word_server #(
        .P_DEPTH    (16),
        .P_TIMEOUT  (16),
        .P_OP_REFIL (2'h1)
    ) dut (
        .clk         (clk),
        .Resetn      (Resetn),
        .enable      (enable),
        .TRNG_Go     (TRNG_Go),
        .Op_Type     (Op_Type),
        .TRNG_Done   (TRNG_Done),
        .trng_data   (trng_data),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .rnd_data    (rnd_data),
        .fill_level  (fill_level),
        .timeout_err (timeout_err)
`ifdef TRNG_REPCHECK_EN
        ,
        .rep_err     (rep_err)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // TRNG responder and consumer model state
    int           cyc;
    logic         resp_en;
    logic         resp_pending;
    int           resp_cd;
    int           resp_delay;
    logic         resp_fixed;
    logic [127:0] fixed_data;
    logic [31:0]  seq;
    int           go_cnt;
    int           go_viol;
    int           done_cnt;
    int           done_step;
    int           first_done_step;
    int           first_valid_step;
    logic [1:0]   op_log[$];
    logic [31:0]  exp_q[$];
    logic [31:0]  popped[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        resp_pending     = 1'b0;
        resp_cd          = 0;
        seq              = 32'hA000_0000;
        go_cnt           = 0;
        go_viol          = 0;
        done_cnt         = 0;
        done_step        = 0;
        first_done_step  = 0;
        first_valid_step = 0;
        op_log.delete();
        exp_q.delete();
        popped.delete();
    endtask

    // One clock: drive inputs at the falling edge, then observe outputs there.
    task automatic tick(input logic rdy);
        @(negedge clk);
        cyc++;
        rnd_ready = rdy;
        TRNG_Done = 1'b0;
        if (resp_pending) begin
            if (resp_cd == 0) begin
                TRNG_Done = 1'b1;
                if (resp_fixed) begin
                    trng_data = fixed_data;
                end else begin
                    trng_data = {seq + 32'd3, seq + 32'd2, seq + 32'd1, seq};
                    seq = seq + 32'd4;
                end
                for (int i = 0; i < 4; i++) exp_q.push_back(trng_data[i*32 +: 32]);
                done_cnt++;
                done_step = cyc;
                if (done_cnt == 1) first_done_step = cyc;
                resp_pending = 1'b0;
            end else begin
                resp_cd--;
            end
        end
        if (TRNG_Go) begin
            go_cnt++;
            op_log.push_back(Op_Type);
            if (fill_level > 5'd12) go_viol++;
            if (resp_en) begin
                resp_pending = 1'b1;
                resp_cd      = resp_delay;
            end
        end
        if (rnd_valid && first_valid_step == 0) first_valid_step = cyc;
        if (rnd_valid && rnd_ready) popped.push_back(rnd_data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Resetn = 1'b0;
        reset_model();
        tick(1'b0);
        tick(1'b0);
        Resetn = 1'b1;
        reset_model();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_go"},    TRNG_Go,     1'b0);
        check_eq({pfx, "_op"},    Op_Type,     2'h0);
        check_eq({pfx, "_valid"}, rnd_valid,   1'b0);
        check_eq({pfx, "_data"},  rnd_data,    32'h0);
        check_eq({pfx, "_fill"},  fill_level,  5'd0);
        check_eq({pfx, "_tmo"},   timeout_err, 1'b0);
    endtask

    initial begin
        int viol;
        int win;
        cyc        = 0;
        Resetn     = 1'b1;
        enable     = 1'b0;
        TRNG_Done  = 1'b0;
        trng_data  = '0;
        rnd_ready  = 1'b0;
        resp_en    = 1'b1;
        resp_delay = 10;
        resp_fixed = 1'b0;
        fixed_data = '0;
        reset_model();
        #3 Resetn = 1'b0;
        tick(1'b0);
        tick(1'b0);
        check_reset_outputs("reset");
        Resetn = 1'b1;

        // 1: fill to 16, INIT then refill op codes, first-word latency
        reset_model();
        enable = 1'b1;
        for (int n = 0; n < 300 && fill_level != 5'd16; n++) tick(1'b0);
        for (int n = 0; n < 40; n++) tick(1'b0);
        check_eq("t1_fill_full", fill_level, 5'd16);
        check_eq("t1_go_count", go_cnt, 4);
        check_eq("t1_go_when_low_space", go_viol, 0);
        if (op_log.size() == 4) begin
            check_eq("t1_op0", op_log[0], 2'h0);
            check_eq("t1_op1", op_log[1], 2'h1);
            check_eq("t1_op3", op_log[3], 2'h1);
        end else begin
            check_eq("t1_op_log_size", op_log.size(), 4);
        end
        check_eq("t1_latency", first_valid_step - first_done_step, 2);
        check_eq("t1_head", rnd_data, 32'hA000_0000);

        // 2: word order of one block
        do_reset();
        resp_fixed = 1'b1;
        fixed_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        enable     = 1'b1;
        for (int n = 0; n < 100 && popped.size() < 4; n++) tick(1'b1);
        if (popped.size() >= 4) begin
            check_eq("t2_word0", popped[0], 32'h1111_1111);
            check_eq("t2_word1", popped[1], 32'h2222_2222);
            check_eq("t2_word2", popped[2], 32'h3333_3333);
            check_eq("t2_word3", popped[3], 32'h4444_4444);
        end else begin
            check_eq("t2_pop_count", popped.size(), 4);
        end
        resp_fixed = 1'b0;

        // 3: TRNG never answers; timeout, then a late Done is ignored
        do_reset();
        resp_en = 1'b0;
        enable  = 1'b1;
        for (int n = 0; n < 20 && go_cnt == 0; n++) tick(1'b0);
        enable = 1'b0;
        check_eq("t3_go_seen", go_cnt, 1);
        for (int k = 1; k <= 18; k++) begin
            tick(1'b0);
            if (k == 14) check_eq("t3_tmo_early", timeout_err, 1'b0);
        end
        check_eq("t3_tmo_set", timeout_err, 1'b1);
        check_eq("t3_fill_after_tmo", fill_level, 5'd0);
        resp_pending = 1'b1;
        resp_cd      = 0;
        for (int n = 0; n < 10; n++) tick(1'b0);
        check_eq("t3_late_done_fill", fill_level, 5'd0);
        check_eq("t3_late_done_valid", rnd_valid, 1'b0);
        check_eq("t3_tmo_sticky", timeout_err, 1'b1);
        check_eq("t3_no_new_go", go_cnt, 1);
        resp_en = 1'b1;

        // 4: FIFO at 12, pop every UNPACK cycle; level stays flat, nothing lost
        do_reset();
        enable = 1'b1;
        viol   = 0;
        win    = 0;
        for (int n = 0; n < 300; n++) begin
            logic rdy;
            rdy = (done_cnt == 4) && (cyc + 1 > done_step) && (cyc + 1 <= done_step + 4);
            tick(rdy);
            if (go_cnt == 4) enable = 1'b0;
            if (done_cnt == 4 && cyc >= done_step + 1 && cyc <= done_step + 6) begin
                win++;
                if (fill_level != 5'd12) viol++;
            end
            if (done_cnt == 4 && cyc >= done_step + 6) break;
        end
        check_eq("t4_window_len", win, 6);
        check_eq("t4_level_flat", viol, 0);
        check_eq("t4_pops_in_unpack", popped.size(), 4);
        for (int n = 0; n < 30; n++) tick(1'b1);
        check_eq("t4_total_pops", popped.size(), 16);
        for (int i = 0; i < 16 && i < popped.size(); i++) begin
            logic [31:0] w;
            w = 32'hA000_0000 + 32'(i);
            check_eq($sformatf("t4_word%0d", i), popped[i], w);
        end
        check_eq("t4_empty_fill", fill_level, 5'd0);
        check_eq("t4_empty_data", rnd_data, 32'h0);

        // 5: reset during WAIT, late Done ignored, next Go is INIT again
        do_reset();
        resp_en = 1'b0;
        enable  = 1'b1;
        for (int n = 0; n < 20 && go_cnt == 0; n++) tick(1'b0);
        check_eq("t5_first_go", go_cnt, 1);
        for (int n = 0; n < 5; n++) tick(1'b0);
        @(negedge clk);
        Resetn = 1'b0;
        enable = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        tick(1'b0);
        tick(1'b0);
        Resetn = 1'b1;
        reset_model();
        resp_pending = 1'b1;
        resp_cd      = 0;
        for (int n = 0; n < 10; n++) tick(1'b0);
        check_eq("t5_done_ignored_fill", fill_level, 5'd0);
        check_eq("t5_done_ignored_valid", rnd_valid, 1'b0);
        check_eq("t5_no_go_disabled", go_cnt, 0);
        enable = 1'b1;
        for (int n = 0; n < 20 && go_cnt == 0; n++) tick(1'b0);
        if (op_log.size() >= 1) check_eq("t5_op_after_reset", op_log[0], 2'h0);
        else check_eq("t5_go_after_reset", go_cnt, 1);
        enable  = 1'b0;
        resp_en = 1'b1;

`ifdef TRNG_REPCHECK_EN
        // 6: identical consecutive blocks; second is dropped
        do_reset();
        resp_fixed = 1'b1;
        fixed_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5;
        enable     = 1'b1;
        for (int n = 0; n < 200 && done_cnt < 2; n++) tick(1'b0);
        enable = 1'b0;
        check_eq("t6_rep_clear_before", rep_err, 1'b0);
        for (int n = 0; n < 10; n++) tick(1'b0);
        check_eq("t6_two_blocks", done_cnt, 2);
        check_eq("t6_fill_once", fill_level, 5'd4);
        check_eq("t6_rep_err", rep_err, 1'b1);
        resp_fixed = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
